// File: rtl/imm_decode_stage.sv
// imm_decode_stage: opcode-derived immediate decode, pc+imm, 2-entry skid buffer, illegal counter.
// Define IMM_RVC_EN to decode 16-bit compressed C.ADDI/C.LI/C.J/C.BEQZ/C.BNEZ.
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [XLEN-1:0]  out_pc,
  output logic [2:0]       out_type,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_target,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);
  localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3, T_U = 3'd4, T_J = 3'd5, T_N = 3'd7;
  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [2:0]      typ;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic            ill;
  } ent_t;
  ent_t             r_ent [2];
  logic [1:0]       r_cnt;
  logic             r_head;
  logic [CNT_W-1:0] r_ill_cnt;
  logic [2:0]       w_typ;
  logic             w_ill;
  logic [XLEN-1:0]  w_imm;
  logic [XLEN-1:0]  w_sh;
  logic             w_push;
  logic             w_pop;
  // Widen an already 32-bit sign-extended value to XLEN.
  function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction
  always_comb begin
    w_typ = T_N;
    w_ill = 1'b1;
    w_imm = '0;
    w_sh = '0;
    w_sh[5:0] = (XLEN == 64) ? in_instr[25:20] : {1'b0, in_instr[24:20]};
    if (in_instr[1:0] == 2'b11) begin
      w_ill = 1'b0;
      case (in_instr[6:0])
        7'b0110011: w_typ = T_R;
        7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
          w_typ = T_I;
          w_imm = (in_instr[6:0] == 7'b0010011 && in_instr[13:12] == 2'b01) ? w_sh
                : sx({{20{in_instr[31]}}, in_instr[31:20]});
        end
        7'b0100011: begin
          w_typ = T_S;
          w_imm = sx({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
        end
        7'b1100011: begin
          w_typ = T_B;
          w_imm = sx({{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0});
        end
        7'b0110111, 7'b0010111: begin
          w_typ = T_U;
          w_imm = sx({in_instr[31:12], 12'h000});
        end
        7'b1101111: begin
          w_typ = T_J;
          w_imm = sx({{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0});
        end
        default: w_ill = 1'b1;
      endcase
    end
`ifdef IMM_RVC_EN
    else if (in_instr[1:0] == 2'b01) begin
      case (in_instr[15:13])
        3'b000, 3'b010: begin
          w_typ = T_I;
          w_ill = 1'b0;
          w_imm = sx({{26{in_instr[12]}}, in_instr[12], in_instr[6:2]});
        end
        3'b101: begin
          w_typ = T_J;
          w_ill = 1'b0;
          w_imm = sx({{20{in_instr[12]}}, in_instr[12], in_instr[8], in_instr[10:9], in_instr[6], in_instr[7],
                      in_instr[2], in_instr[11], in_instr[5:3], 1'b0});
        end
        3'b110, 3'b111: begin
          w_typ = T_B;
          w_ill = 1'b0;
          w_imm = sx({{23{in_instr[12]}}, in_instr[12], in_instr[6:5], in_instr[2], in_instr[11:10],
                      in_instr[4:3], 1'b0});
        end
        default: w_ill = 1'b1;
      endcase
    end
`endif
  end
  assign in_ready    = r_cnt != 2'd2;
  assign out_valid   = r_cnt != 2'd0;
  assign w_push      = in_valid & in_ready;
  assign w_pop       = out_valid & out_ready;
  assign out_instr   = r_ent[r_head].instr;
  assign out_pc      = r_ent[r_head].pc;
  assign out_type    = r_ent[r_head].typ;
  assign out_imm     = r_ent[r_head].imm;
  assign out_target  = r_ent[r_head].target;
  assign out_illegal = r_ent[r_head].ill;
  assign illegal_cnt = r_ill_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_head <= 1'b0;
      r_ill_cnt <= '0;
      for (int k = 0; k < 2; k++) begin
        r_ent[k] <= '0;
        r_ent[k].typ <= T_N;
      end
    end else begin
      if (w_push) r_ent[r_head ^ r_cnt[0]] <= '{in_instr, in_pc, w_typ, w_imm, in_pc + w_imm, w_ill};
      if (w_pop) r_head <= ~r_head;
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
      if (w_push && w_ill && r_ill_cnt != '1) r_ill_cnt <= r_ill_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: scoreboard bench with a behavioural decode model and randomized traffic.
module tb_imm_decode_stage;
  localparam int XLEN = 32;
  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [31:0]     in_instr = '0;
  logic [XLEN-1:0] in_pc = '0;
  logic            in_ready, out_valid, out_illegal;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc, out_imm, out_target;
  logic [2:0]      out_type;
  logic [15:0]     illegal_cnt;
  logic            s_in_ready, s_out_valid, s_out_illegal;
  logic [31:0]     s_out_instr;
  logic [XLEN-1:0] s_out_pc, s_out_imm, s_out_target;
  logic [2:0]      s_out_type;
  logic [1:0]      s_cnt;
  always #5 clk = ~clk;
  imm_decode_stage #(.XLEN(XLEN), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .out_type(out_type),
    .out_imm(out_imm), .out_target(out_target), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt));
  imm_decode_stage #(.XLEN(XLEN), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_instr(s_out_instr), .out_pc(s_out_pc),
    .out_type(s_out_type), .out_imm(s_out_imm), .out_target(s_out_target), .out_illegal(s_out_illegal),
    .illegal_cnt(s_cnt));
  typedef struct {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc, imm, target;
    logic [2:0]      typ;
    logic            ill;
  } exp_t;
  exp_t q[$];
  int n_chk = 0, n_pass = 0, n_ill = 0, rdy_mode = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, want);
  endtask
  function automatic exp_t model(input logic [31:0] i, input logic [XLEN-1:0] pc);
    exp_t e;
    longint imm = 0;
    logic [63:0] u;
    int t = 7;
    bit ill = 1;
`ifdef IMM_RVC_EN
    int jmap[11] = '{11, 4, 9, 8, 10, 6, 7, 3, 2, 1, 5};
    int bhi[3] = '{8, 4, 3};
    int blo[5] = '{7, 6, 2, 1, 5};
    logic [11:0] off = '0;
`endif
    if (i[1:0] == 2'b11) begin
      ill = 0;
      case (i[6:0])
        7'h33: t = 0;
        7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: begin
          t = 1;
          imm = $signed(i[31:20]);
          if (i[6:0] == 7'h13 && (i[14:12] == 3'd1 || i[14:12] == 3'd5)) imm = (XLEN == 64) ? i[25:20] : i[24:20];
        end
        7'h23: begin t = 2; imm = $signed({i[31:25], i[11:7]}); end
        7'h63: begin t = 3; imm = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0}); end
        7'h37, 7'h17: begin t = 4; imm = $signed({i[31:12], 12'h000}); end
        7'h6F: begin t = 5; imm = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0}); end
        default: ill = 1;
      endcase
    end
`ifdef IMM_RVC_EN
    else if (i[1:0] == 2'b01) begin
      if (i[15:13] == 3'd0 || i[15:13] == 3'd2) begin
        t = 1; ill = 0; imm = $signed({i[12], i[6:2]});
      end else if (i[15:13] == 3'd5) begin
        for (int k = 0; k < 11; k++) off[jmap[k]] = i[12-k];
        t = 5; ill = 0; imm = longint'(off) - (off[11] ? 4096 : 0);
      end else if (i[15:13] >= 3'd6) begin
        for (int k = 0; k < 3; k++) off[bhi[k]] = i[12-k];
        for (int k = 0; k < 5; k++) off[blo[k]] = i[6-k];
        t = 3; ill = 0; imm = longint'(off) - (off[8] ? 512 : 0);
      end
    end
`endif
    u = imm;
    e.instr = i;
    e.pc = pc;
    e.typ = 3'(t);
    e.ill = ill;
    e.imm = u[XLEN-1:0];
    e.target = pc + e.imm;
    return e;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        e = q.pop_front();
        chk("instr", out_instr, e.instr);
        chk("pc", out_pc, e.pc);
        chk("type", out_type, e.typ);
        chk("imm", out_imm, e.imm);
        chk("target", out_target, e.target);
        chk("illegal", out_illegal, e.ill);
      end
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
  end
  task automatic send(input logic [31:0] i, input logic [XLEN-1:0] pc);
    int w = 0;
    exp_t e;
    in_valid = 1'b1;
    in_instr = i;
    in_pc = pc;
    while (!in_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    e = model(i, pc);
    q.push_back(e);
    if (e.ill) n_ill++;
    @(negedge clk);
  endtask
  task automatic drain();
    int w = 0;
    in_valid = 1'b0;
    while ((q.size() != 0 || out_valid) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("drain", q.size() == 0 && !out_valid, 1);
  endtask
  function automatic logic [31:0] rand_instr();
    logic [6:0] ops[11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    logic [31:0] r = $urandom;
    int k = $urandom_range(0, 13);
    if (k < 11) r[6:0] = ops[k];
    if (r[6:0] == 7'h13 && $urandom_range(0, 1) == 1) r[13:12] = 2'b01;
    return r;
  endfunction
  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_type", out_type, 7);
    chk("rst_imm", out_imm, 0);
    chk("rst_target", out_target, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_illegal", out_illegal, 0);
    chk("rst_cnt", illegal_cnt, 0);
    @(negedge clk);
    send(32'hFFF00093, 32'h100);
    chk("addi_latency_valid", out_valid, 1);
    chk("addi_type", out_type, 1);
    chk("addi_imm", out_imm, 32'hFFFFFFFF);
    chk("addi_target", out_target, 32'h000000FF);
    in_valid = 1'b0;
    @(negedge clk);
    send(32'hFE000EE3, 32'h200);
    chk("beq_type", out_type, 3);
    chk("beq_imm", out_imm, 32'hFFFFFFFC);
    chk("beq_target", out_target, 32'h1FC);
    in_valid = 1'b0;
    @(negedge clk);
    send(32'h4030D093, 32'h300);
    chk("srai_imm", out_imm, 32'h3);
    chk("srai_type", out_type, 1);
    repeat (3) send(32'h0000007F, 32'h400);
    drain();
    chk("ill_cnt3", illegal_cnt, 3);
    chk("sat_cnt3", s_cnt, 3);
    repeat (2) send(32'h0000007F, 32'h404);
    drain();
    chk("ill_cnt5", illegal_cnt, 5);
    chk("sat_cnt_hold", s_cnt, 3);
    send(32'h000050FD, 32'h500);
`ifdef IMM_RVC_EN
    chk("cli_type", out_type, 1);
    chk("cli_imm", out_imm, 32'hFFFFFFFF);
    chk("cli_illegal", out_illegal, 0);
`else
    chk("cli_type", out_type, 7);
    chk("cli_illegal", out_illegal, 1);
`endif
    drain();
    rdy_mode = 1;
    repeat (2) @(negedge clk);
    send(32'h00A00513, 32'h600);
    send(32'h00B00593, 32'h604);
    in_instr = 32'h00C00613;
    in_pc = 32'h608;
    chk("bp_in_ready_low", in_ready, 0);
    @(negedge clk);
    chk("bp_in_ready_hold", in_ready, 0);
    chk("bp_head_first", out_instr, 32'h00A00513);
    rdy_mode = 0;
    send(32'h00C00613, 32'h608);
    drain();
    rdy_mode = 1;
    repeat (2) @(negedge clk);
    send(32'h0000007F, 32'h700);
    send(32'h00D00693, 32'h704);
    in_valid = 1'b0;
    chk("flush_full", in_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    n_ill = 0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_cnt", illegal_cnt, 0);
    rdy_mode = 2;
    repeat (2) @(negedge clk);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      send(rand_instr(), XLEN'($urandom));
    end
    drain();
    chk("rand_ill_cnt", illegal_cnt, (n_ill > 65535) ? 65535 : n_ill);
    chk("rand_sat_cnt", s_cnt, (n_ill > 3) ? 3 : n_ill);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
Registered immediate-decode pipeline stage for the RV core, placed between fetch and execute.
- Derives instruction format from the opcode itself; no externally supplied type.
- Builds a sign-extended immediate at parametrised XLEN, with shift-amount handling.
- Precomputes pc+imm.
- Decouples fetch and execute through a 2-entry valid/ready skid buffer.
- Counts illegal encodings.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
CNT_W, 16, width of the saturating illegal-instruction counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  upstream has an instruction
in_ready  out  1  stage can accept; high when buffer count < 2
in_instr  in  32  raw instruction word
in_pc  in  XLEN  PC of in_instr
out_valid  out  1  head entry valid
out_ready  in  1  downstream accepts head entry
out_instr  out  32  instruction passthrough
out_pc  out  XLEN  PC passthrough
out_type  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, N=7
out_imm  out  XLEN  decoded immediate
out_target  out  XLEN  out_pc + out_imm, modulo 2^XLEN
out_illegal  out  1  opcode not recognised
illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values:
  - Buffer count = 0, so out_valid = 0 and in_ready = 1 on the first cycle after reset.
  - out_instr, out_pc, out_imm, out_target = 0; out_type = 7; out_illegal = 0; illegal_cnt = 0.
- Reset mid-operation: flushes both entries without presenting them; inputs are ignored while reset is high.
- Handshake:
  - Accept when in_valid & in_ready. Pop when out_valid & out_ready.
  - The in_valid and out_valid sides must each hold stable until their handshake completes.
  - Latency: an instruction accepted on edge N is presented with out_valid = 1 after edge N. Minimum 1 cycle.
  - Order is strictly FIFO.
  - Push and pop in the same cycle leave count unchanged.
  - At count = 2, in_ready = 0, so no push can occur.
  - in_ready is derived only from registered count; there is no combinational path from out_ready.
- Decode and compute happen at accept time; results are stored in the buffer entry.
- Opcode (instr[6:0]) to format:
  - 0110011 -> R
  - 0010011, 0000011, 1100111, 1110011, 0001111 -> I
  - 0100011 -> S
  - 1100011 -> B
  - 0110111, 0010111 -> U
  - 1101111 -> J
  - anything else, or instr[1:0] != 11 -> N, illegal = 1, imm = 0
- Immediates, all sign-extended from instr[31] to XLEN:
  - R: imm = 0.
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - U: {instr[31:12], 12'h000}; when XLEN = 64, bits 63:32 are a copy of instr[31].
- Shift exception: for opcode 0010011 with funct3 = 001 or 101, imm is the zero-extended shamt.
  - XLEN = 32: shamt = instr[24:20].
  - XLEN = 64: shamt = instr[25:20].
- out_target = pc + imm is computed for every format. Consumers ignore it where it has no meaning.
- illegal_cnt: increments by 1 on each accepted instruction with illegal = 1. It saturates at all-ones and does not wrap.

Optional Feature:
Macro: IMM_RVC_EN
- Defined: an instruction with instr[1:0] != 11 is decoded as a 16-bit compressed instruction (upper 16 bits ignored). Supported forms:
  - quadrant 01, funct3 000 (C.ADDI) or 010 (C.LI): type I, imm = sext({i[12], i[6:2]}).
  - quadrant 01, funct3 101 (C.J): type J, offset[11|4|9:8|10|6|7|3:1|5] = i[12:2], sign-extended.
  - quadrant 01, funct3 110/111 (C.BEQZ/C.BNEZ): type B, offset[8|4:3] = i[12:10], offset[7:6|2:1|5] = i[6:2], sign-extended.
  - Any other compressed encoding: N, illegal.
- Not defined: every instruction with instr[1:0] != 11 is N, illegal = 1, imm = 0. No RVC logic is synthesised.

Test Plan:
1. in_instr 0xFFF00093 (ADDI), in_pc 0x100 -> out_type 1, out_imm 0xFFFFFFFF, out_target 0x000000FF, out_valid one cycle after accept.
2. in_instr 0xFE000EE3 (BEQ -4), in_pc 0x200 -> out_type 3, out_imm 0xFFFFFFFC, out_target 0x1FC.
3. in_instr 0x4030D093 (SRAI x1,x1,3) -> out_type 1, out_imm 0x00000003, not 0x403.
4. Hold out_ready = 0 and offer 3 instructions -> in_ready drops after the 2nd; raise out_ready -> all 3 emerge in order with no loss or duplication. Assert reset with 2 entries buffered -> out_valid = 0 on the next cycle.
5. in_instr 0x0000007F, accepted 3 times -> out_type 7, out_illegal 1, out_imm 0, illegal_cnt = 3. With CNT_W = 2 and 5 illegal instructions accepted -> illegal_cnt stays at 3.
6. in_instr 0x000050FD (C.LI x1,-1): with IMM_RVC_EN -> out_type 1, out_imm 0xFFFFFFFF, out_illegal 0; without IMM_RVC_EN -> out_type 7, out_illegal 1.
